// File: rtl/tube_driver_pkg.sv
// rtl/tube_driver_pkg.sv - shared register map, digit codes and segment table for tube_driver
package tube_driver_pkg;

  localparam logic [1:0] ADDR_VALUE = 2'd0;
  localparam logic [1:0] ADDR_CTRL  = 2'd1;

  localparam int CTRL_MODE_BIT  = 0;
  localparam int CTRL_BLANK_LSB = 8;
  localparam int CTRL_DP_LSB    = 16;

  // Buffer codes: 0-F are hex digits, the extra code is the overflow dash.
  typedef logic [4:0] code_t;
  localparam code_t CODE_DASH = 5'h10;

  // Active-low {g,f,e,d,c,b,a}; dp is appended by the display path.
  function automatic logic [6:0] seg_decode(input code_t c);
    case (c)
      5'h00:   seg_decode = 7'h40;
      5'h01:   seg_decode = 7'h79;
      5'h02:   seg_decode = 7'h24;
      5'h03:   seg_decode = 7'h30;
      5'h04:   seg_decode = 7'h19;
      5'h05:   seg_decode = 7'h12;
      5'h06:   seg_decode = 7'h02;
      5'h07:   seg_decode = 7'h78;
      5'h08:   seg_decode = 7'h00;
      5'h09:   seg_decode = 7'h10;
      5'h0A:   seg_decode = 7'h08;
      5'h0B:   seg_decode = 7'h03;
      5'h0C:   seg_decode = 7'h46;
      5'h0D:   seg_decode = 7'h21;
      5'h0E:   seg_decode = 7'h06;
      5'h0F:   seg_decode = 7'h0E;
      default: seg_decode = 7'h3F;
    endcase
  endfunction

endpackage

// File: rtl/tube_driver_bin2bcd_seq.sv
// rtl/tube_driver_bin2bcd_seq.sv - one-bit-per-cycle double-dabble converter, 32-bit binary to 8 BCD digits
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] bin_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        ovf_o,
  output logic [31:0] bcd_o
);

  logic [31:0] bin_q, bin_d;
  logic [31:0] bcd_q, bcd_d;
  logic [31:0] bcd_adj;
  logic [31:0] bcd_shift;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        ovf_q, ovf_d;

  // A 1 leaving the top digit means the running prefix passed 99_999_999,
  // so the sticky carry-out doubles as the overflow flag.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 8; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_shift = {bcd_adj[30:0], bin_q[31]};
  end

  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    ovf_d  = ovf_q;
    if (start_i) begin
      bin_d  = bin_i;
      bcd_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
      ovf_d  = 1'b0;
    end else if (abort_i) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      bin_d = {bin_q[30:0], 1'b0};
      bcd_d = bcd_shift;
      cnt_d = cnt_q + 5'd1;
      ovf_d = ovf_q | bcd_adj[31];
      if (cnt_q == 5'd31) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      ovf_q  <= ovf_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == 5'd31) && !start_i && !abort_i;
  assign ovf_o  = ovf_q | bcd_adj[31];
  assign bcd_o  = bcd_shift;

endmodule

// File: rtl/tube_driver.sv
// rtl/tube_driver.sv - MMIO 8-digit multiplexed 7-segment driver with hex or decimal display
module tube_driver
  import tube_driver_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic [7:0]  tube_en,
  output logic [7:0]  tube_seg
);

  localparam int PW = $clog2(SCAN_DIV);

  logic [31:0]   value_q, value_d;
  logic          mode_q, mode_d;
  logic [7:0]    blank_q, blank_d;
  logic [7:0]    dp_q, dp_d;
  code_t         buf_q [8];
  code_t         buf_d [8];
  logic          start_q, start_d;
  logic          abort_q, abort_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    en_q, en_d;
  logic [7:0]    seg_q, seg_d;
  logic          wr_value, wr_ctrl;
  logic          conv_done, conv_ovf;
  logic [31:0]   conv_bcd;
  logic [6:0]    glyph;

  assign wr_value = wr_en && (wr_addr == ADDR_VALUE);
  assign wr_ctrl  = wr_en && (wr_addr == ADDR_CTRL);

  bin2bcd_seq u_conv (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_q),
    .abort_i (abort_q),
    .bin_i   (value_q),
    .busy_o  (busy),
    .done_o  (conv_done),
    .ovf_o   (conv_ovf),
    .bcd_o   (conv_bcd)
  );

  always_comb begin
    value_d = value_q;
    mode_d  = mode_q;
    blank_d = blank_q;
    dp_d    = dp_q;
    start_d = 1'b0;
    abort_d = 1'b0;
    if (wr_value) begin
      value_d = wr_data;
      start_d = mode_q;
    end
    if (wr_ctrl) begin
      mode_d  = wr_data[CTRL_MODE_BIT];
      blank_d = wr_data[CTRL_BLANK_LSB +: 8];
      dp_d    = wr_data[CTRL_DP_LSB +: 8];
      start_d = wr_data[CTRL_MODE_BIT];
      abort_d = !wr_data[CTRL_MODE_BIT];
    end
  end

  // Hex mode tracks VALUE continuously; decimal mode only changes on a finished conversion.
  always_comb begin
    buf_d = buf_q;
    if (!mode_q) begin
      for (int i = 0; i < 8; i++) buf_d[i] = {1'b0, value_q[4*i +: 4]};
    end else if (conv_done) begin
      for (int i = 0; i < 8; i++) buf_d[i] = conv_ovf ? CODE_DASH : {1'b0, conv_bcd[4*i +: 4]};
    end
  end

  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = idx_q + 3'd1;
    end
    glyph = seg_decode(buf_q[idx_q]);
    en_d  = ~(8'd1 << idx_q);
    seg_d = {~dp_q[idx_q], glyph};
    if (blank_q[idx_q]) begin
      en_d  = 8'hFF;
      seg_d = 8'hFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
      mode_q  <= 1'b0;
      blank_q <= '0;
      dp_q    <= '0;
      buf_q   <= '{default: '0};
      start_q <= 1'b0;
      abort_q <= 1'b0;
      presc_q <= '0;
      idx_q   <= '0;
      en_q    <= 8'hFF;
      seg_q   <= 8'hFF;
    end else begin
      value_q <= value_d;
      mode_q  <= mode_d;
      blank_q <= blank_d;
      dp_q    <= dp_d;
      buf_q   <= buf_d;
      start_q <= start_d;
      abort_q <= abort_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      seg_q   <= seg_d;
    end
  end

  assign tube_en  = en_q;
  assign tube_seg = seg_q;

endmodule

// File: tb/tb_tube_driver.sv
// tb/tb_tube_driver.sv - scoreboard bench for tube_driver with a behavioural display model
module tb_tube_driver;

  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        busy;
  logic [7:0]  tube_en, tube_seg;

  tube_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .tube_en(tube_en), .tube_seg(tube_seg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] en;
    logic [63:0] seg;
  } frame_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          last_wr = 0;
  frame_t      fq[$];
  int          bq[$];
  bit          fmon_active = 1'b0;
  logic [31:0] m_value = '0;
  logic [31:0] m_ctrl = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
    end
  endtask

  function automatic logic [7:0] glyph(input int d);
    case (d)
      0: return 8'hC0;   1: return 8'hF9;   2: return 8'hA4;   3: return 8'hB0;
      4: return 8'h99;   5: return 8'h92;   6: return 8'h82;   7: return 8'hF8;
      8: return 8'h80;   9: return 8'h90;   10: return 8'h88;  11: return 8'h83;
      12: return 8'hC6;  13: return 8'hA1;  14: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  function automatic frame_t build_frame();
    frame_t f;
    longint v;
    longint p;
    logic [7:0] g;
    v = longint'(m_value);
    p = 1;
    for (int i = 0; i < 8; i++) begin
      if (!m_ctrl[0])           g = glyph(int'((v >> (4 * i)) & 15));
      else if (v > 99999999)    g = 8'hBF;
      else                      g = glyph(int'((v / p) % 10));
      p = p * 10;
      if (m_ctrl[8 + i]) begin
        f.en[8*i +: 8]  = 8'hFF;
        f.seg[8*i +: 8] = 8'hFF;
      end else begin
        f.en[8*i +: 8]  = ~(8'd1 << i);
        f.seg[8*i +: 8] = {~m_ctrl[16 + i], g[6:0]};
      end
    end
    return f;
  endfunction

  // Frame monitor: one full scan (32 cycles) must be a rotation of the expected slot sequence.
  initial begin : frame_monitor
    frame_t     f;
    logic [7:0] oen [32];
    logic [7:0] oseg [32];
    logic [63:0] got_en, got_seg;
    bit         ok, rot_ok;
    forever begin
      @(negedge clk); #1;
      if (fq.size() > 0) begin
        fmon_active = 1'b1;
        f = fq.pop_front();
        for (int j = 0; j < 32; j++) begin
          oen[j]  = tube_en;
          oseg[j] = tube_seg;
          if (j < 31) begin @(negedge clk); #1; end
        end
        ok = 1'b0;
        for (int r = 0; r < 32; r++) begin
          rot_ok = 1'b1;
          for (int j = 0; j < 32; j++) begin
            if (oen[j] != f.en[8*(((j + r) % 32) / 4) +: 8] ||
                oseg[j] != f.seg[8*(((j + r) % 32) / 4) +: 8]) rot_ok = 1'b0;
          end
          if (rot_ok) ok = 1'b1;
        end
        for (int k = 0; k < 8; k++) begin
          got_en[8*k +: 8]  = oen[4*k];
          got_seg[8*k +: 8] = oseg[4*k];
        end
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL frame: got en=%h seg=%h (every 4th sample) want en=%h seg=%h (slot7..0)",
                   got_en, got_seg, f.en, f.seg);
        end
        fmon_active = 1'b0;
      end
    end
  end

  // Busy monitor: rise 2 cycles after the starting write; fall delay checked against the queue.
  initial begin : busy_monitor
    logic prev;
    int   want;
    prev = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (busy && !prev) chk("busy_rise_delay", cyc - last_wr, 2);
      if (!busy && prev) begin
        if (bq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL busy_fall: got unexpected busy window want none");
        end else begin
          want = bq.pop_front();
          chk("busy_fall_delay", rst ? -1 : cyc - last_wr, want);
        end
      end
      prev = busy;
    end
  end

  task automatic do_write(input logic [1:0] a, input logic [31:0] d, input bit push, output bit conv);
    conv = (a == 2'd0 && m_ctrl[0]) || (a == 2'd1 && d[0]);
    if (conv && push) bq.push_back(34);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d; last_wr = cyc;
    if (a == 2'd0) m_value = d;
    else if (a == 2'd1) m_ctrl = d & 32'h00FF_FF01;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_busy(input logic level, input int budget, input string what);
    int n;
    n = 0;
    while (busy !== level && n < budget) begin @(negedge clk); #1; n++; end
    if (busy !== level) begin
      checks++;
      errors++;
      $display("FAIL %s: got busy=%0b want %0b within %0d cycles", what, busy, level, budget);
    end
  endtask

  task automatic settle(input bit conv);
    if (conv) begin
      wait_busy(1'b1, 5, "busy_start");
      wait_busy(1'b0, 60, "busy_end");
    end
    repeat (3) @(negedge clk);
    fq.push_back(build_frame());
    @(negedge clk);
    for (int n = 0; n < 200 && (fq.size() != 0 || fmon_active); n++) @(negedge clk);
    if (fq.size() != 0 || fmon_active) begin
      checks++;
      errors++;
      $display("FAIL frame_wait: got monitor still busy want idle");
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish before 1ms");
    $fatal(1);
  end

  initial begin : stimulus
    bit          conv;
    logic [1:0]  a;
    logic [31:0] d;

    repeat (3) @(negedge clk);
    #2;
    chk("reset_busy", busy, 0);
    chk("reset_en", tube_en, 8'hFF);
    chk("reset_seg", tube_seg, 8'hFF);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #2;
    chk("first_scan_en", tube_en, 8'hFE);
    chk("first_scan_seg", tube_seg, 8'hC0);

    do_write(2'd0, 32'h1234ABCD, 1'b1, conv); settle(conv);
    do_write(2'd1, 32'h0001F000, 1'b1, conv); settle(conv);

    do_write(2'd1, 32'h1, 1'b1, conv); settle(conv);
    do_write(2'd0, 32'd12345678, 1'b1, conv); settle(conv);

    do_write(2'd0, 32'd100000000, 1'b0, conv);
    wait_busy(1'b1, 5, "abort_first_start");
    repeat (5) @(negedge clk);
    do_write(2'd0, 32'd42, 1'b1, conv); settle(conv);

    do_write(2'd0, 32'd777, 1'b0, conv);
    wait_busy(1'b1, 5, "hexswitch_start");
    repeat (7) @(negedge clk);
    bq.push_back(2);
    do_write(2'd1, 32'h0, 1'b1, conv); settle(conv);

    do_write(2'd2, 32'hDEADBEEF, 1'b1, conv);
    do_write(2'd3, 32'hFFFFFFFF, 1'b1, conv); settle(conv);

    for (int it = 0; it < 20; it++) begin
      a = 2'($urandom_range(0, 3));
      if (a == 2'd0 && $urandom_range(0, 1) == 1) d = $urandom_range(0, 99999999);
      else d = $urandom;
      do_write(a, d, 1'b1, conv); settle(conv);
    end

    do_write(2'd1, 32'h1, 1'b1, conv); settle(conv);
    do_write(2'd0, $urandom_range(0, 99999999), 1'b0, conv);
    wait_busy(1'b1, 5, "reset_conv_start");
    repeat (10) @(negedge clk);
    bq.push_back(-1);
    rst = 1'b1;
    m_value = '0;
    m_ctrl  = '0;
    #2;
    chk("midconv_reset_busy", busy, 0);
    chk("midconv_reset_en", tube_en, 8'hFF);
    chk("midconv_reset_seg", tube_seg, 8'hFF);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    settle(1'b0);

    chk("busy_queue_drained", bq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
